// File: rtl/norm_pkg.sv
// Shared types and defaults for the sequential normalizer.
package norm_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/norm_step.sv
// One combinational normalize step: shift by 1 or 4 toward the target end, plus target/nibble flags.
module norm_step
    import norm_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic             step4,
    output logic [WIDTH-1:0] shifted,
    output logic             target_bit,
    output logic             nib_zero
);

    always_comb begin
        shifted    = '0;
        target_bit = 1'b0;
        nib_zero   = 1'b0;
        if (dir == DIR_LEFT) begin
            target_bit = data[WIDTH-1];
            nib_zero   = (data[WIDTH-1 -: 4] == 4'b0000);
            shifted    = step4 ? (data << 4) : (data << 1);
        end else begin
            target_bit = data[0];
            nib_zero   = (data[3:0] == 4'b0000);
            shifted    = step4 ? (data >> 4) : (data >> 1);
        end
    end

endmodule

// File: rtl/seq_normalizer.sv
// Multi-cycle leading/trailing-zero normalizer with start/done handshake.
// Optional nibble skip enabled by defining SEQ_NORM_FAST_SKIP_EN.
module seq_normalizer
    import norm_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic             Dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out,
    output logic [CNT_W-1:0] Cnt,
    output logic             Zero
);

`ifdef SEQ_NORM_FAST_SKIP_EN
    localparam logic FAST_SKIP = 1'b1;
`else
    localparam logic FAST_SKIP = 1'b0;
`endif

    state_t           state;
    logic [WIDTH-1:0] data;
    logic             dir_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] shifted;
    logic             target_bit;
    logic             nib_zero;
    logic             skip;
    logic [CNT_W-1:0] cnt_inc;

    // A zero nibble at the target end implies at least four more shifts, so skipping cannot overshoot.
    assign skip    = FAST_SKIP & nib_zero;
    assign cnt_inc = skip ? CNT_W'(4) : CNT_W'(1);

    norm_step #(.WIDTH(WIDTH)) u_step (
        .data       (data),
        .dir        (dir_q),
        .step4      (skip),
        .shifted    (shifted),
        .target_bit (target_bit),
        .nib_zero   (nib_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Out   <= '0;
            Cnt   <= '0;
            Zero  <= 1'b0;
            data  <= '0;
            dir_q <= DIR_LEFT;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        data  <= In;
                        dir_q <= Dir;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (data == '0) begin
                        Out   <= '0;
                        Cnt   <= '0;
                        Zero  <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (target_bit) begin
                        Out   <= data;
                        Cnt   <= cnt;
                        Zero  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        data <= shifted;
                        cnt  <= cnt + cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer against a zero-counting reference model.
module tb_seq_normalizer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] In;
    logic        Dir;
    logic        busy;
    logic        done;
    logic [15:0] Out;
    logic [3:0]  Cnt;
    logic        Zero;

    int n_cmp;
    int n_err;

    seq_normalizer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .In    (In),
        .Dir   (Dir),
        .busy  (busy),
        .done  (done),
        .Out   (Out),
        .Cnt   (Cnt),
        .Zero  (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zeros between the operand's target end and its first set bit.
    function automatic int zeros_to_target(input logic [15:0] v, input logic d);
        int n = 0;
        if (v == 16'h0) return 0;
        if (d == 1'b0) begin
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) break;
                n++;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (v[i]) break;
                n++;
            end
        end
        return n;
    endfunction

    // Edges after the accepting edge until done rises.
    function automatic int expected_latency(input logic [15:0] v, input logic d);
        int z = zeros_to_target(v, d);
        int edges = 1;
        if (v == 16'h0) return 1;
`ifdef SEQ_NORM_FAST_SKIP_EN
        while (z >= 4) begin
            z -= 4;
            edges++;
        end
`endif
        return edges + z;
    endfunction

    // Drives one operation and waits (bounded) for done; returns edges counted from the accepting edge.
    task automatic do_op(input logic [15:0] v, input logic d, output int edges, output logic busy_at_done);
        @(negedge clk);
        In    = v;
        Dir   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        busy_at_done = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        In    = '0;
        Dir   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, Out, Cnt, Zero} !== 23'h0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b Out=%h Cnt=%0d Zero=%b, want all 0", busy, done, Out, Cnt, Zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_leading();
        int edges;
        logic b;
        do_op(16'h00F0, 1'b0, edges, b);
        n_cmp++;
        if (edges !== expected_latency(16'h00F0, 1'b0)) begin
            n_err++;
            $display("FAIL lead_latency: got %0d edges, want %0d", edges, expected_latency(16'h00F0, 1'b0));
        end
        n_cmp++;
        if ({Out, Cnt, Zero, b} !== {16'hF000, 4'd8, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL lead_result: got Out=%h Cnt=%0d Zero=%b busy=%b, want F000 8 0 0", Out, Cnt, Zero, b);
        end
    endtask

    task automatic test_trailing();
        int edges;
        logic b;
        do_op(16'h8000, 1'b1, edges, b);
        n_cmp++;
        if (edges !== expected_latency(16'h8000, 1'b1)) begin
            n_err++;
            $display("FAIL trail_latency: got %0d edges, want %0d", edges, expected_latency(16'h8000, 1'b1));
        end
        n_cmp++;
        if ({Out, Cnt, Zero} !== {16'h0001, 4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL trail_result: got Out=%h Cnt=%0d Zero=%b, want 0001 15 0", Out, Cnt, Zero);
        end
    endtask

    task automatic test_zero_norm();
        int edges;
        logic b;
        do_op(16'h0000, 1'b0, edges, b);
        n_cmp++;
        if (edges !== 1) begin
            n_err++;
            $display("FAIL zero_latency: got %0d edges, want 1", edges);
        end
        n_cmp++;
        if ({Out, Cnt, Zero} !== {16'h0000, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL zero_result: got Out=%h Cnt=%0d Zero=%b, want 0000 0 1", Out, Cnt, Zero);
        end
        do_op(16'h8001, 1'b0, edges, b);
        n_cmp++;
        if (edges !== 1) begin
            n_err++;
            $display("FAIL norm_latency: got %0d edges, want 1", edges);
        end
        n_cmp++;
        if ({Out, Cnt, Zero} !== {16'h8001, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL norm_result: got Out=%h Cnt=%0d Zero=%b, want 8001 0 0", Out, Cnt, Zero);
        end
    endtask

    task automatic test_handshake();
        int edges;
        logic b;
        @(negedge clk);
        In    = 16'h0001;
        Dir   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: got %b, want 1", busy);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        In    = 16'hFFFF;
        Dir   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 4;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_cmp++;
        if (edges !== expected_latency(16'h0001, 1'b0)) begin
            n_err++;
            $display("FAIL ignored_start_latency: got %0d edges, want %0d", edges, expected_latency(16'h0001, 1'b0));
        end
        n_cmp++;
        if ({Out, Cnt, Zero} !== {16'h8000, 4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL ignored_start_result: got Out=%h Cnt=%0d Zero=%b, want 8000 15 0", Out, Cnt, Zero);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, Out, Cnt, Zero} !== {1'b0, 1'b0, 16'h8000, 4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL hold: got busy=%b done=%b Out=%h Cnt=%0d Zero=%b, want 0 0 8000 15 0", busy, done, Out, Cnt, Zero);
        end
        // Second operation is requested during the done cycle of the first.
        do_op(16'h00F0, 1'b0, edges, b);
        @(negedge clk);
        In    = 16'h0004;
        Dir   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL back_to_back_accept: got busy=%b done=%b, want 1 0", busy, done);
        end
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_cmp++;
        if ({Out, Cnt, Zero} !== {16'h0001, 4'd2, 1'b0} || edges !== expected_latency(16'h0004, 1'b1)) begin
            n_err++;
            $display("FAIL back_to_back_result: got Out=%h Cnt=%0d Zero=%b edges=%0d, want 0001 2 0 %0d",
                     Out, Cnt, Zero, edges, expected_latency(16'h0004, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        In    = 16'h0001;
        Dir   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, Out, Cnt, Zero} !== 23'h0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b Out=%h Cnt=%0d Zero=%b, want all 0", busy, done, Out, Cnt, Zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL reset_abort: got %0d cycles with done/busy after reset, want 0", pulses);
        end
    endtask

    task automatic test_random(input int n_ops);
        int edges;
        logic b;
        logic [31:0] r;
        logic [15:0] v;
        logic [15:0] exp_out;
        logic [15:0] back;
        logic d;
        int z;
        for (int k = 0; k < n_ops; k++) begin
            r = $urandom;
            v = r[15:0];
            if ($urandom_range(0, 1) == 0) v = v >> $urandom_range(0, 15);
            else                           v = v << $urandom_range(0, 15);
            if ($urandom_range(0, 31) == 0) v = 16'h0;
            d = 1'($urandom_range(0, 1));
            do_op(v, d, edges, b);
            z = zeros_to_target(v, d);
            exp_out = (d == 1'b0) ? (v << z) : (v >> z);
            n_cmp++;
            if ({Out, Cnt, Zero} !== {exp_out, 4'(z), (v == 16'h0)} || edges !== expected_latency(v, d) || b !== 1'b0) begin
                n_err++;
                $display("FAIL random_op: In=%h Dir=%b got Out=%h Cnt=%0d Zero=%b edges=%0d busy=%b, want %h %0d %b %0d 0",
                         v, d, Out, Cnt, Zero, edges, b, exp_out, z, (v == 16'h0), expected_latency(v, d));
            end
            if (v != 16'h0) begin
                back = (d == 1'b0) ? (Out >> Cnt) : (Out << Cnt);
                n_cmp++;
                if (back !== v) begin
                    n_err++;
                    $display("FAIL round_trip: In=%h Dir=%b restored %h, want %h", v, d, back, v);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_leading();
        test_trailing();
        test_zero_norm();
        test_handshake();
        test_reset_mid();
        test_random(2000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
